// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch FSM state type and fetch-stage constants.
package cpu_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_pc_unit.sv
// pc_unit: program counter with hold / +4 / word-aligned redirect next-PC mux.
module pc_unit import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    logic [31:0] pc_q, pc_d;

    always_comb begin
        pc4  = pc_q + 32'd4;
        pc_d = redirect_valid ? {redirect_target[31:2], 2'b00} : advance ? pc4 : pc_q;
    end

    always_ff @(posedge clock) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: fetch FSM issuing one imem read at a time into a one-entry
// instruction buffer presented to IF/ID, with hazard hold and redirect drain.
module if_fetch_stage import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hazard_hold,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] Inst,
    output logic [31:0] Pc4
);

    fetch_state_e state_q, state_d;
    logic         buf_valid_q, buf_valid_d;
    logic [31:0]  buf_inst_q, buf_inst_d;
    logic [31:0]  pc;
    logic         capture, consume, outstanding;

    pc_unit #(.RESET_PC(RESET_PC)) u_pc_unit (
        .clock           (clock),
        .reset           (reset),
        .advance         (consume),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc4             (Pc4)
    );

    // A full buffer parks the FSM in WAIT; only an empty WAIT has a read in flight.
    always_comb begin
        capture     = state_q == S_WAIT && !buf_valid_q && imem_rsp_valid;
        consume     = buf_valid_q && !hazard_hold;
        outstanding = (state_q == S_REQ && imem_req_ready) ||
                      ((state_q == S_DRAIN || (state_q == S_WAIT && !buf_valid_q)) && !imem_rsp_valid);
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_inst_d  = capture ? imem_rsp_data : buf_inst_q;
        if (redirect_valid) begin
            state_d     = outstanding ? S_DRAIN : S_REQ;
            buf_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_REQ;
                S_REQ:   state_d = imem_req_ready ? S_WAIT : S_REQ;
                S_WAIT:  state_d = consume ? S_REQ : S_WAIT;
                S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
            buf_valid_d = capture || (buf_valid_q && hazard_hold);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            buf_valid_q <= 1'b0;
            buf_inst_q  <= NOP_INST;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_inst_q  <= buf_inst_d;
        end
    end

    assign imem_req_valid = state_q == S_REQ;
    assign imem_req_addr  = pc;
    assign Inst           = buf_valid_q ? buf_inst_q : NOP_INST;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vector table plus hand-written corner sequences
// against a variable-latency instruction memory model.
module tb_if_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hazard_hold = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] Inst;
    logic [31:0] Pc4;

    int          checks = 0;
    int          errors = 0;
    int          lat = 0;
    int          pend_n = 0;
    logic [31:0] pend_addr = 32'h0;

    typedef struct {
        logic        hold;
        logic        redir;
        logic [31:0] tgt;
        logic        ready;
        int          latency;
        logic        e_rv;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[21];

    if_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clock           (clock),
        .reset           (reset),
        .hazard_hold     (hazard_hold),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .Inst            (Inst),
        .Pc4             (Pc4)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a == 32'h108) ? 32'h8C22_0004 : {~a[15:0], a[15:0]};
    endfunction

    // Memory model: a response pulses lat cycles after the accepting edge's cycle.
    always @(posedge clock) begin
        if (reset) pend_n <= 0;
        else if (imem_req_valid && imem_req_ready) begin
            pend_addr <= imem_req_addr;
            pend_n    <= lat + 1;
        end else if (pend_n > 0) pend_n <= pend_n - 1;
    end

    assign imem_rsp_valid = pend_n == 1;
    assign imem_rsp_data  = mw(pend_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_out(input string tag, input logic rv, input logic [31:0] addr,
                           input logic [31:0] inst, input logic [31:0] pc4);
        chk({tag, " req_valid"}, {31'h0, imem_req_valid}, {31'h0, rv});
        chk({tag, " req_addr"}, imem_req_addr, addr);
        chk({tag, " Inst"}, Inst, inst);
        chk({tag, " Pc4"}, Pc4, pc4);
    endtask

    function automatic vec_t v(input logic hold, input logic redir, input logic [31:0] tgt,
                               input int latency, input logic rv, input logic [31:0] addr,
                               input logic [31:0] inst, input logic [31:0] pc4);
        vec_t r;
        r.hold = hold; r.redir = redir; r.tgt = tgt; r.ready = 1'b1; r.latency = latency;
        r.e_rv = rv; r.e_addr = addr; r.e_inst = inst; r.e_pc4 = pc4;
        return r;
    endfunction

    initial begin
        vecs[0]  = v(0, 0, 0, 0, 1, 32'h100, 0, 32'h104);
        vecs[1]  = v(0, 0, 0, 0, 0, 32'h100, 0, 32'h104);
        vecs[2]  = v(0, 0, 0, 0, 0, 32'h100, mw(32'h100), 32'h104);
        vecs[3]  = v(0, 0, 0, 0, 1, 32'h104, 0, 32'h108);
        vecs[4]  = v(0, 0, 0, 0, 0, 32'h104, 0, 32'h108);
        vecs[5]  = v(0, 0, 0, 0, 0, 32'h104, mw(32'h104), 32'h108);
        vecs[6]  = v(0, 0, 0, 0, 1, 32'h108, 0, 32'h10C);
        vecs[7]  = v(0, 0, 0, 0, 0, 32'h108, 0, 32'h10C);
        vecs[8]  = v(0, 0, 0, 0, 0, 32'h108, 32'h8C22_0004, 32'h10C);
        vecs[9]  = v(1, 0, 0, 0, 0, 32'h108, 32'h8C22_0004, 32'h10C);
        vecs[10] = v(1, 0, 0, 0, 0, 32'h108, 32'h8C22_0004, 32'h10C);
        vecs[11] = v(1, 0, 0, 0, 0, 32'h108, 32'h8C22_0004, 32'h10C);
        vecs[12] = v(0, 0, 0, 4, 1, 32'h10C, 0, 32'h110);
        vecs[13] = v(0, 0, 0, 4, 0, 32'h10C, 0, 32'h110);
        vecs[14] = v(0, 1, 32'h2003, 4, 0, 32'h2000, 0, 32'h2004);
        vecs[15] = v(0, 0, 0, 4, 0, 32'h2000, 0, 32'h2004);
        vecs[16] = v(0, 0, 0, 4, 0, 32'h2000, 0, 32'h2004);
        vecs[17] = v(0, 0, 0, 4, 0, 32'h2000, 0, 32'h2004);
        vecs[18] = v(0, 0, 0, 0, 1, 32'h2000, 0, 32'h2004);
        vecs[19] = v(0, 0, 0, 0, 0, 32'h2000, 0, 32'h2004);
        vecs[20] = v(0, 0, 0, 0, 0, 32'h2000, mw(32'h2000), 32'h2004);

        repeat (2) cyc();
        chk_out("reset", 0, 32'h100, 0, 32'h104);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            hazard_hold     = vecs[i].hold;
            redirect_valid  = vecs[i].redir;
            redirect_target = vecs[i].tgt;
            imem_req_ready  = vecs[i].ready;
            lat             = vecs[i].latency;
            cyc();
            chk_out($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_inst, vecs[i].e_pc4);
        end
        redirect_valid = 1'b0;

        // Redirect in the same cycle as the response: no drain, immediate request.
        cyc();
        chk_out("consume2000", 1, 32'h2004, 0, 32'h2008);
        cyc();
        chk("rsp_pulse", {31'h0, imem_rsp_valid}, 32'h1);
        redirect_valid = 1'b1; redirect_target = 32'h3000;
        cyc();
        chk_out("redir_rsp", 1, 32'h3000, 0, 32'h3004);
        redirect_valid = 1'b0;
        cyc();
        cyc();
        chk_out("fetch3000", 0, 32'h3000, mw(32'h3000), 32'h3004);

        // Stalled request retargeted by a redirect.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_out($sformatf("stall%0d", i), 1, 32'h3004, 0, 32'h3008);
        end
        redirect_valid = 1'b1; redirect_target = 32'h40;
        cyc();
        chk_out("retarget", 1, 32'h40, 0, 32'h44);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        cyc();
        chk_out("accept40", 0, 32'h40, 0, 32'h44);
        cyc();
        chk_out("fetch40", 0, 32'h40, mw(32'h40), 32'h44);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        cyc();
        chk_out("to_top", 1, 32'hFFFF_FFFC, 0, 32'h0);
        redirect_valid = 1'b0;
        cyc();
        cyc();
        chk_out("fetch_top", 0, 32'hFFFF_FFFC, mw(32'hFFFF_FFFC), 32'h0);
        cyc();
        chk_out("wrap", 1, 32'h0, 0, 32'h4);
        cyc();
        cyc();
        chk_out("fetch0", 0, 32'h0, mw(32'h0), 32'h4);

        // Reset in the middle of an outstanding read.
        cyc();
        chk_out("consume0", 1, 32'h4, 0, 32'h8);
        lat = 4;
        cyc();
        chk_out("wait4", 0, 32'h4, 0, 32'h8);
        reset = 1'b1;
        cyc();
        chk_out("mid_reset", 0, 32'h100, 0, 32'h104);
        reset = 1'b0; lat = 0;
        cyc();
        chk_out("post_reset", 1, 32'h100, 0, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
